// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : score_pkg
//  Description : Shared constants and types for the score RAM read side:
//                address map, query type codes and reader state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package score_pkg;

  localparam int ADDR_W      = 3;
  localparam int DATA_W      = 5;
  localparam int HIGH_ADDR   = 5;
  localparam int WINNER_ADDR = 6;
  localparam int PLAYER_BASE = 0;

  // Dump walks 0,1,2,3,5,6: word 4 is an unused hole, 7 is past the end
  localparam int DUMP_FIRST  = 0;
  localparam int DUMP_SKIP   = 4;
  localparam int DUMP_LAST   = 6;

  typedef enum logic [1:0] {
    QT_PLAYER = 2'b00,
    QT_HIGH   = 2'b01,
    QT_WINNER = 2'b10,
    QT_DUMP   = 2'b11
  } qtype_e;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_GRANT = 3'd1,
    S_ISSUE      = 3'd2,
    S_WAIT       = 3'd3,
    S_CATCH      = 3'd4,
    S_NEXT       = 3'd5,
    S_RELEASE    = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/score_query_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : score_query_reader_if
//  Description : Query request/response and RAM read port bundle of the
//                score query reader. Signal directions are named from the
//                reader's point of view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface score_query_reader_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 5
);
  logic              i_query_req;
  logic [1:0]        i_query_type;
  logic [1:0]        i_player_id;
  logic              i_ram_grant;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [DATA_W-1:0] i_ram_data;
  logic [DATA_W-1:0] o_data_out;
  logic [ADDR_W-1:0] o_data_tag;
  logic              o_data_valid;
  logic              o_query_done;
  logic              o_busy;

  // Reader side
  modport slave (
    input  i_query_req, i_query_type, i_player_id, i_ram_grant, i_ram_data,
    output o_ram_addr, o_data_out, o_data_tag, o_data_valid, o_query_done, o_busy
  );

  // Requester / RAM owner side
  modport master (
    output i_query_req, i_query_type, i_player_id, i_ram_grant, i_ram_data,
    input  o_ram_addr, o_data_out, o_data_tag, o_data_valid, o_query_done, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/score_dump_seq.sv
`default_nettype none
// ============================================================================
//  Module      : score_dump_seq
//  Description : Address generator for the leaderboard dump: first address,
//                successor of the current address (hopping over the unused
//                word) and last-address flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module score_dump_seq #(
  parameter int ADDR_W = 3
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic [ADDR_W-1:0] o_first,
  output logic [ADDR_W-1:0] o_next,
  output logic              o_last
);
  import score_pkg::*;

  localparam logic [ADDR_W-1:0] C_FIRST = ADDR_W'(DUMP_FIRST);
  localparam logic [ADDR_W-1:0] C_SKIP  = ADDR_W'(DUMP_SKIP);
  localparam logic [ADDR_W-1:0] C_LAST  = ADDR_W'(DUMP_LAST);

  logic [ADDR_W-1:0] w_inc;

  // Step to the next populated word, hopping over the hole
  always_comb begin
    o_first = C_FIRST;
    w_inc   = i_addr + 1'b1;
    o_next  = (w_inc == C_SKIP) ? (w_inc + 1'b1) : w_inc;
    o_last  = (i_addr == C_LAST);
  end

endmodule
`default_nettype wire

// File: rtl/score_query_reader.sv
`default_nettype none
// ============================================================================
//  Module      : score_query_reader
//  Description : Answers leaderboard queries by reading the shared score RAM
//                while the tracker grants access. One word per request, or
//                a six-word dump. Read-only with respect to the RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module score_query_reader #(
  parameter int ADDR_W      = score_pkg::ADDR_W,
  parameter int DATA_W      = score_pkg::DATA_W,
  parameter int RD_WAIT     = 2,
  parameter int HIGH_ADDR   = score_pkg::HIGH_ADDR,
  parameter int WINNER_ADDR = score_pkg::WINNER_ADDR
) (
  input  logic                clk,
  input  logic                rst,
  score_query_reader_if.slave bus
);
  import score_pkg::*;

  localparam int              CNT_W      = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(RD_WAIT - 1);

  state_e            r_state;
  state_e            w_next;
  qtype_e            r_qtype;
  logic [ADDR_W-1:0] r_addr;      // address of the word currently being fetched
  logic [ADDR_W-1:0] r_ram_addr;
  logic [ADDR_W-1:0] r_tag;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_done;
  logic              r_busy;
  logic [CNT_W-1:0]  r_cnt;

  logic [ADDR_W-1:0] w_first_addr;
  logic [ADDR_W-1:0] w_dump_first;
  logic [ADDR_W-1:0] w_dump_next;
  logic              w_dump_last;
  logic              w_last;
  logic              w_grant;

  score_dump_seq #(.ADDR_W(ADDR_W)) u_dump_seq (
    .i_addr  (r_addr),
    .o_first (w_dump_first),
    .o_next  (w_dump_next),
    .o_last  (w_dump_last)
  );

  assign w_grant = bus.i_ram_grant;
  // Single-word queries always finish on their only word
  assign w_last  = (r_qtype != QT_DUMP) || w_dump_last;

  // First address of a query, decoded from the live request inputs
  always_comb begin
    w_first_addr = w_dump_first;
    unique case (qtype_e'(bus.i_query_type))
      QT_PLAYER: w_first_addr = ADDR_W'(PLAYER_BASE) | ADDR_W'(bus.i_player_id);
      QT_HIGH:   w_first_addr = ADDR_W'(HIGH_ADDR);
      QT_WINNER: w_first_addr = ADDR_W'(WINNER_ADDR);
      QT_DUMP:   w_first_addr = w_dump_first;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; losing the grant anywhere in a fetch restarts that word
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:       if (bus.i_query_req) w_next = w_grant ? S_ISSUE : S_WAIT_GRANT;
      S_WAIT_GRANT: if (w_grant) w_next = S_ISSUE;
      S_ISSUE:      w_next = w_grant ? S_WAIT : S_WAIT_GRANT;
      S_WAIT: begin
        if (!w_grant)                w_next = S_WAIT_GRANT;
        else if (r_cnt == C_CNT_LAST) w_next = S_CATCH;
      end
      S_CATCH: begin
        if (!w_grant)    w_next = S_WAIT_GRANT;
        else if (w_last) w_next = S_RELEASE;
        else             w_next = S_NEXT;
      end
      S_NEXT:       w_next = S_ISSUE;
      S_RELEASE:    if (!bus.i_query_req) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // Datapath: query latch, address walk, read-wait counter and output pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_qtype    <= QT_PLAYER;
      r_addr     <= '0;
      r_ram_addr <= '0;
      r_tag      <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= (w_next != S_IDLE);
      unique case (r_state)
        S_IDLE: begin
          if (bus.i_query_req) begin
            r_qtype <= qtype_e'(bus.i_query_type);
            r_addr  <= w_first_addr;
          end
        end
        S_ISSUE: begin
          if (w_grant) r_ram_addr <= r_addr;
          r_cnt <= '0;
        end
        S_WAIT:  r_cnt <= r_cnt + 1'b1;
        S_CATCH: begin
          if (w_grant) begin
            r_data  <= bus.i_ram_data;
            r_tag   <= r_ram_addr;
            r_valid <= 1'b1;
            r_done  <= w_last;
          end
        end
        S_NEXT:  r_addr <= w_dump_next;
        default: ;
      endcase
    end
  end

  assign bus.o_ram_addr   = r_ram_addr;
  assign bus.o_data_out   = r_data;
  assign bus.o_data_tag   = r_tag;
  assign bus.o_data_valid = r_valid;
  assign bus.o_query_done = r_done;
  assign bus.o_busy       = r_busy;

endmodule
`default_nettype wire
